// File: rtl/vram_pkg.sv
// Shared types and default geometry for the VRAM Wishbone controller.
// Holds the 640x480x8bpp framebuffer size and the FSM/grant encodings.
package vram_pkg;

    localparam logic [31:0] VramBase  = 32'h0000_0000;
    localparam int unsigned VramWords = 76800;
    localparam int unsigned VramAw    = 17;

    typedef enum logic {
        StIdle,
        StAck
    } vram_state_e;

    typedef enum logic [1:0] {
        GntNone,
        GntVid,
        GntCpu
    } vram_gnt_e;

endpackage

// File: rtl/vram_wb_ctrl_if.sv
// Wishbone classic port bundle; one instance per master (video, CPU).
// wdat is master-to-slave write data, rdat is slave-to-master read data.
interface vram_wb_ctrl_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, sel, wdat,
        input  rdat, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, wdat,
        output rdat, ack, err, rty
    );

endinterface

// File: rtl/vram_bram.sv
// Single-port 32-bit RAM with byte write enables and one-cycle registered read,
// coded for block-RAM inference (read-first).
module vram_bram #(
    parameter int unsigned Depth = 76800,
    parameter int unsigned Aw    = 17
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [Aw-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/vram_wb_ctrl.sv
// Two-master Wishbone arbiter onto the framebuffer RAM (video has priority, read-only).
// Define VRAM_RANGE_CHK_EN to turn out-of-window addresses into err instead of wrapping.
module vram_wb_ctrl
    import vram_pkg::*;
#(
    parameter logic [31:0] BASE  = VramBase,
    parameter int unsigned WORDS = VramWords,
    parameter int unsigned AW    = VramAw
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    vram_wb_ctrl_if.slave v,
    vram_wb_ctrl_if.slave c
);

    vram_state_e st_q, st_d;
    vram_gnt_e   gnt_q, gnt_d, gnt_idle;
    logic        err_q, err_d, rd_q, rd_d;
    logic [31:0] v_dat_q, c_dat_q;

    logic          v_req, c_req, gnt_cyc;
    logic          acc, acc_we, bad, in_range;
    logic [31:0]   acc_adr, offs, word_idx;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata, rd_term;
    logic          v_rd_done, c_rd_done;
    logic          unused_sig;

    assign v_req = v.cyc & v.stb;
    assign c_req = c.cyc & c.stb;

    // Access decode for the IDLE cycle; a fresh grant takes effect immediately.
    always_comb begin
        gnt_idle = gnt_q;
        if (gnt_q == GntNone) begin
            if (v_req) begin
                gnt_idle = GntVid;
            end else if (c_req) begin
                gnt_idle = GntCpu;
            end
        end
        acc      = (st_q == StIdle) &&
                   (((gnt_idle == GntVid) && v_req) || ((gnt_idle == GntCpu) && c_req));
        acc_adr  = (gnt_idle == GntCpu) ? c.adr : v.adr;
        acc_we   = (gnt_idle == GntCpu) ? c.we : v.we;
        offs     = acc_adr - BASE;
        word_idx = offs >> 2;
`ifdef VRAM_RANGE_CHK_EN
        in_range = (acc_adr >= BASE) && (word_idx < 32'(WORDS));
`else
        in_range = 1'b1;
`endif
        bad      = !in_range || ((gnt_idle == GntVid) && v.we);
        ram_en   = acc && wb_rst_i;
        ram_we   = (ram_en && acc_we && !bad) ? c.sel : 4'b0000;
        gnt_cyc  = (gnt_q == GntVid) ? v.cyc : ((gnt_q == GntCpu) ? c.cyc : 1'b0);
    end

    vram_bram #(
        .Depth (WORDS),
        .Aw    (AW)
    ) u_bram (
        .clk_i   (wb_clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (word_idx[AW-1:0]),
        .wdata_i (c.wdat),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            st_q    <= StIdle;
            gnt_q   <= GntNone;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            v_dat_q <= 32'h0;
            c_dat_q <= 32'h0;
        end else begin
            st_q  <= st_d;
            gnt_q <= gnt_d;
            err_q <= err_d;
            rd_q  <= rd_d;
            if (v_rd_done) v_dat_q <= rd_term;
            if (c_rd_done) c_dat_q <= rd_term;
        end
    end

    always_comb begin
        st_d  = st_q;
        gnt_d = gnt_q;
        err_d = err_q;
        rd_d  = rd_q;
        unique case (st_q)
            StIdle: begin
                if (acc) begin
                    st_d  = StAck;
                    gnt_d = gnt_idle;
                    err_d = bad;
                    rd_d  = !acc_we;
                end else if (!gnt_cyc) begin
                    gnt_d = GntNone;
                end
            end
            StAck: begin
                st_d  = StIdle;
                gnt_d = gnt_cyc ? gnt_q : GntNone;
            end
            default: st_d = StIdle;
        endcase
    end

    always_comb begin
        v.ack     = (st_q == StAck) && (gnt_q == GntVid) && !err_q;
        v.err     = (st_q == StAck) && (gnt_q == GntVid) && err_q;
        c.ack     = (st_q == StAck) && (gnt_q == GntCpu) && !err_q;
        c.err     = (st_q == StAck) && (gnt_q == GntCpu) && err_q;
        v.rty     = 1'b0;
        c.rty     = 1'b0;
        rd_term   = err_q ? 32'h0 : ram_rdata;
        v_rd_done = (st_q == StAck) && (gnt_q == GntVid) && rd_q;
        c_rd_done = (st_q == StAck) && (gnt_q == GntCpu) && rd_q;
        v.rdat    = v_rd_done ? rd_term : v_dat_q;
        c.rdat    = c_rd_done ? rd_term : c_dat_q;
    end

    // Video port never writes, and high index bits are discarded when wrapping.
    assign unused_sig = ^{v.wdat, v.sel, word_idx};

endmodule

// File: tb/tb_vram_wb_ctrl.sv
// Directed, scoreboard-based bench for vram_wb_ctrl (two Wishbone masters).
module tb_vram_wb_ctrl;
    import vram_pkg::*;

    localparam logic [31:0] Base = 32'h0000_0000;
`ifdef VRAM_RANGE_CHK_EN
    localparam logic RangeErr = 1'b1;
`else
    localparam logic RangeErr = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;

    logic [31:0] model [int unsigned];
    logic [31:0] rd_q [$];
    logic [31:0] v_q [$];

    vram_wb_ctrl_if v_if ();
    vram_wb_ctrl_if c_if ();

    vram_wb_ctrl dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .v        (v_if),
        .c        (c_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input bit cpu, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat, input logic exp_err,
                        input bit chk_dat, input string tag);
        int unsigned idx;
        int          n;
        logic [31:0] m, e, rdat;
        logic        ack, err;
        idx = (adr - Base) >> 2;
        if (cpu) begin
            c_if.cyc = 1; c_if.stb = 1; c_if.we = we; c_if.adr = adr; c_if.sel = sel;
            c_if.wdat = dat;
        end else begin
            v_if.cyc = 1; v_if.stb = 1; v_if.we = we; v_if.adr = adr; v_if.sel = sel;
            v_if.wdat = dat;
        end
        if (!we && chk_dat) rd_q.push_back(exp_err ? 32'h0 : model[idx]);
        if (we && !exp_err) begin
            m = model.exists(idx) ? model[idx] : 32'h0;
            for (int i = 0; i < 4; i++) if (sel[i]) m[8*i +: 8] = dat[8*i +: 8];
            model[idx] = m;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            ack  = cpu ? c_if.ack : v_if.ack;
            err  = cpu ? c_if.err : v_if.err;
            rdat = cpu ? c_if.rdat : v_if.rdat;
        end while (!ack && !err && n < 8);
        check({tag, " latency"}, n, 1);
        check({tag, " ack"}, {31'h0, ack}, {31'h0, !exp_err});
        check({tag, " err"}, {31'h0, err}, {31'h0, exp_err});
        if (!we && chk_dat) begin
            e = rd_q.pop_front();
            check({tag, " data"}, rdat, e);
        end
        c_if.cyc = 0; c_if.stb = 0; c_if.we = 0;
        v_if.cyc = 0; v_if.stb = 0; v_if.we = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        int k, last_v, cpu_cyc;
        bit cpu_early;
        logic [31:0] e;
        v_if.cyc = 0; v_if.stb = 0; v_if.we = 0; v_if.adr = 0; v_if.sel = 0; v_if.wdat = 0;
        c_if.cyc = 0; c_if.stb = 0; c_if.we = 0; c_if.adr = 0; c_if.sel = 0; c_if.wdat = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset v ack", {31'h0, v_if.ack}, 32'h0);
        check("reset v err", {31'h0, v_if.err}, 32'h0);
        check("reset c ack", {31'h0, c_if.ack}, 32'h0);
        check("reset c err", {31'h0, c_if.err}, 32'h0);
        check("reset rty", {30'h0, v_if.rty, c_if.rty}, 32'h0);
        check("reset v dat", v_if.rdat, 32'h0);
        check("reset c dat", c_if.rdat, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;

        xfer(1, 1, Base + 32'h10, 4'hf, 32'hA1B2_C3D4, 0, 0, "cpu wr 0x10");
        xfer(0, 0, Base + 32'h10, 4'hf, 32'h0, 0, 1, "vid rd 0x10");
        xfer(1, 1, Base + 32'd20, 4'hf, 32'hFFFF_FFFF, 0, 0, "cpu wr w5 ones");
        xfer(1, 1, Base + 32'd20, 4'b0101, 32'h0, 0, 0, "cpu wr w5 sel0101");
        xfer(1, 0, Base + 32'd20, 4'hf, 32'h0, 0, 1, "cpu rd w5");
        xfer(1, 1, Base + 32'h10, 4'b0000, 32'h0, 0, 0, "cpu wr sel0000");
        xfer(1, 0, Base + 32'h10, 4'hf, 32'h0, 0, 1, "cpu rd after sel0000");
        xfer(0, 1, Base + 32'd20, 4'hf, 32'h1234_5678, 1, 0, "vid wr err");
        xfer(1, 0, Base + 32'd20, 4'hf, 32'h0, 0, 1, "cpu rd w5 after vid wr");
        xfer(1, 0, Base + 32'd307200, 4'hf, 32'h0, RangeErr, RangeErr, "cpu rd word 76800");

        for (int i = 0; i < 160; i++) begin
            xfer(1, 1, Base + 32'(4 * (100 + i)), 4'hf, 32'hC0DE_0000 + 32'(i), 0, 0, "preload");
        end

        // Simultaneous request: video wins and streams 160 words before CPU gets served.
        v_if.cyc = 1; v_if.stb = 1; v_if.we = 0; v_if.adr = Base + 32'd400;
        c_if.cyc = 1; c_if.stb = 1; c_if.we = 0; c_if.adr = Base + 32'h10;
        v_q.push_back(model[100]);
        rd_q.push_back(model[4]);
        k = 0; last_v = 0; cpu_cyc = 0; cpu_early = 0;
        for (int t = 1; t <= 400 && cpu_cyc == 0; t++) begin
            @(posedge clk); #1;
            if (c_if.ack || c_if.err) begin
                cpu_cyc = t;
                if (k < 160) cpu_early = 1;
                e = rd_q.pop_front();
                check("arb cpu data", c_if.rdat, e);
                c_if.cyc = 0; c_if.stb = 0;
            end
            if (v_if.ack) begin
                e = v_q.pop_front();
                check("burst data", v_if.rdat, e);
                k++;
                last_v = t;
                if (k == 160) begin
                    v_if.cyc = 0; v_if.stb = 0;
                end else begin
                    v_if.adr = v_if.adr + 32'd4;
                    v_q.push_back(model[100 + k]);
                end
            end
        end
        c_if.cyc = 0; c_if.stb = 0; v_if.cyc = 0; v_if.stb = 0;
        check("burst words", k, 160);
        check("burst last ack cycle", last_v, 319);
        check("cpu ack cycle", cpu_cyc, 321);
        check("cpu ack during burst", {31'h0, cpu_early}, 32'h0);
        @(posedge clk); #1;

        // Reset lands in the ACK cycle of a CPU read.
        c_if.cyc = 1; c_if.stb = 1; c_if.we = 0; c_if.adr = Base + 32'h10;
        @(posedge clk); #1;
        check("pre-reset ack", {31'h0, c_if.ack}, 32'h1);
        rst_n = 0;
        c_if.we = 1; c_if.sel = 4'hf; c_if.wdat = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("rst c ack", {31'h0, c_if.ack}, 32'h0);
        check("rst c err", {31'h0, c_if.err}, 32'h0);
        check("rst v ack", {31'h0, v_if.ack}, 32'h0);
        check("rst c dat", c_if.rdat, 32'h0);
        check("rst state", 32'(dut.st_q), 32'(StIdle));
        check("rst grant", 32'(dut.gnt_q), 32'(GntNone));
        @(posedge clk); #1;
        c_if.cyc = 0; c_if.stb = 0; c_if.we = 0;
        rst_n = 1;
        @(posedge clk); #1;
        xfer(1, 0, Base + 32'h10, 4'hf, 32'h0, 0, 1, "post-reset rd");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
